st_packet_channel_arbiter: RTL
==============================

ST_PACKET_CHANNEL_ARBITER -- requirements
Module: st_packet_channel_arbiter

Interface
REQ-001 Parameter NUM_INPUTS, default 2: number of Avalon-ST requester ports, legal range 2..8.
REQ-002 Parameter DATA_W, default 8: symbol width of every data path.
REQ-003 Parameter CHANNEL_W, default 8: width of out_channel, at least clog2(NUM_INPUTS).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  NUM_INPUTS  per-requester valid, bit i for port i.
REQ-007 in_ready  output  NUM_INPUTS  per-requester ready, bit i for port i.
REQ-008 in_data  input  NUM_INPUTS*DATA_W  packed data, port i at bits [i*DATA_W +: DATA_W].
REQ-009 in_startofpacket  input  NUM_INPUTS  per-requester SOP.
REQ-010 in_endofpacket  input  NUM_INPUTS  per-requester EOP.
REQ-011 out_ready  input  1  downstream ready, ready latency 0.
REQ-012 out_valid  output  1  registered output valid.
REQ-013 out_data  output  DATA_W  registered output data.
REQ-014 out_channel  output  CHANNEL_W  registered index of the source port, zero-extended.
REQ-015 out_startofpacket  output  1  registered SOP.
REQ-016 out_endofpacket  output  1  registered EOP.

Function
REQ-017 The block SHALL time-share one channelized output stream between NUM_INPUTS packet streams, with grants made at packet granularity.
REQ-018 Beat acceptance on port i SHALL be in_valid[i] && in_ready[i]; output transfer SHALL be out_valid && out_ready.
REQ-019 The output stage SHALL be one register; slot_free = !out_valid || out_ready.
REQ-020 in_ready[i] SHALL be asserted only when port i is the current grant and slot_free; all other bits SHALL be 0.
REQ-021 An accepted beat SHALL appear on the out_* registers on the next clock edge, for a fixed latency of 1 cycle.
REQ-022 out_channel SHALL equal the index of the port that supplied the beat.
REQ-023 The state machine SHALL have two states: IDLE (no port locked) and LOCKED (grant held on lock_idx).
REQ-024 In IDLE, the grant SHALL be chosen combinationally by round-robin over in_valid, searching from last_grant+1 modulo NUM_INPUTS.
REQ-025 In IDLE with no in_valid bit set, there SHALL be no grant and in_ready SHALL be all zeros.
REQ-026 In IDLE, when a beat is accepted without EOP: go to LOCKED, set lock_idx to the granted port, and set last_grant to the granted port.
REQ-027 In IDLE, when a beat is accepted with EOP (single-beat packet): stay in IDLE and set last_grant to the granted port.
REQ-028 In IDLE, when a grant is made but slot_free=0: make no state change; arbitration SHALL be re-evaluated next cycle.
REQ-029 In LOCKED, the grant SHALL be lock_idx regardless of other in_valid bits.
REQ-030 In LOCKED, an accepted beat with EOP SHALL return the FSM to IDLE, and that beat SHALL be forwarded normally.
REQ-031 SOP is not checked: the first accepted beat in IDLE opens the lock whether or not in_startofpacket is set.
REQ-032 A mid-packet SOP SHALL be forwarded unchanged and SHALL NOT affect the lock.
REQ-033 When out_valid && !out_ready, all out_* registers SHALL hold their values.
REQ-034 When out_ready=1 and no beat is accepted, out_valid SHALL go to 0; the other out_* registers keep their previous values.
REQ-035 Throughput SHALL be one beat per cycle when the upstream and downstream are continuously valid and ready, including back-to-back packets from different ports.

Reset
REQ-036 While reset_n=0: out_valid=0, out_data=0, out_channel=0, out_startofpacket=0, out_endofpacket=0, in_ready=0, FSM=IDLE, lock_idx=0, last_grant=NUM_INPUTS-1 (port 0 has first priority).
REQ-037 Assertion of reset mid-packet SHALL immediately drop the lock and any held output beat; no partial-packet recovery is provided.
REQ-038 After reset_n deasserts, the block SHALL resume operation on the first clock edge.

Verification
REQ-039 Both ports issue single-beat packets every cycle and out_ready=1 -> out_channel alternates 0,1,0,1, starting with 0, with one beat per cycle.
REQ-040 Port 0 sends a 4-beat packet (data 0x10..0x13) while port 1 is valid -> four beats on channel 0 (SOP on the first, EOP on the last), then port 1 is granted; in_ready[1]=0 throughout the port-0 packet.
REQ-041 out_ready is held 0 for 3 cycles while out_valid=1 with data 0xA5 -> out_* hold 0xA5 for the whole stall, in_ready=0, and there is no data loss or duplication after release.
REQ-042 NUM_INPUTS=4 with only ports 1 and 3 valid, last_grant=1 -> next grant is 3, then 1.
REQ-043 reset_n pulsed low for 1 cycle in the middle of a port-1 packet -> outputs go to their reset values asynchronously; the next grant goes to port 0 if it is valid.
REQ-044 Port 0 sends a beat with EOP and no SOP in IDLE -> the beat is forwarded on channel 0 and the FSM stays in IDLE.

Source files
------------

// File: rtl/st_packet_channel_arbiter.sv
// Packet-granular round-robin arbiter: multiplexes NUM_INPUTS Avalon-ST streams
// onto one registered, channelized output stream, holding the grant until EOP.
module st_packet_channel_arbiter #(
    parameter int NUM_INPUTS = 2,
    parameter int DATA_W     = 8,
    parameter int CHANNEL_W  = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_INPUTS-1:0]        in_valid,
    output logic [NUM_INPUTS-1:0]        in_ready,
    input  logic [NUM_INPUTS*DATA_W-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]        in_startofpacket,
    input  logic [NUM_INPUTS-1:0]        in_endofpacket,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [CHANNEL_W-1:0]         out_channel,
    output logic                         out_startofpacket,
    output logic                         out_endofpacket
);
    localparam int              IDX_W     = $clog2(NUM_INPUTS);
    localparam logic [0:0]      ST_IDLE   = 1'b0;
    localparam logic [0:0]      ST_LOCKED = 1'b1;
    localparam logic [IDX_W:0]  NUM_L     = (IDX_W+1)'(NUM_INPUTS);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_INPUTS - 1);

    logic [0:0]           state_q, state_d;
    logic [IDX_W-1:0]     lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic [CHANNEL_W-1:0] out_channel_q, out_channel_d;
    logic                 out_sop_q, out_sop_d;
    logic                 out_eop_q, out_eop_d;

    logic                 rr_found_s;
    logic [IDX_W-1:0]     rr_idx_s;
    logic [IDX_W:0]       rr_sum_s;
    logic [IDX_W-1:0]     rr_wrap_s;
    logic [IDX_W-1:0]     rr_cand_s;
    logic                 grant_valid_s;
    logic [IDX_W-1:0]     grant_idx_s;
    logic                 slot_free_s;
    logic                 accept_s;
    logic [DATA_W-1:0]    sel_data_s;
    logic                 sel_sop_s;
    logic                 sel_eop_s;
    logic [NUM_INPUTS-1:0] in_ready_s;

    // Round-robin search over in_valid starting just after the last granted port
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = {IDX_W{1'b0}};
        rr_sum_s   = {(IDX_W+1){1'b0}};
        rr_wrap_s  = {IDX_W{1'b0}};
        rr_cand_s  = {IDX_W{1'b0}};
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            rr_sum_s   = {1'b0, last_grant_q} + (IDX_W+1)'(k);
            rr_wrap_s  = rr_sum_s[IDX_W-1:0] - NUM_L[IDX_W-1:0];
            rr_cand_s  = (rr_sum_s >= NUM_L) ? rr_wrap_s : rr_sum_s[IDX_W-1:0];
            rr_idx_s   = (!rr_found_s && in_valid[rr_cand_s]) ? rr_cand_s : rr_idx_s;
            rr_found_s = rr_found_s | in_valid[rr_cand_s];
        end
    end

    // Grant source: the locked port while a packet is open, otherwise the RR winner
    always_comb begin
        if (state_q == ST_LOCKED) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = lock_idx_q;
        end else begin
            grant_valid_s = rr_found_s;
            grant_idx_s   = rr_idx_s;
        end
    end

    assign slot_free_s = !out_valid_q || out_ready;
    assign accept_s    = grant_valid_s && slot_free_s && in_valid[grant_idx_s];
    assign sel_data_s  = in_data[grant_idx_s*DATA_W +: DATA_W];
    assign sel_sop_s   = in_startofpacket[grant_idx_s];
    assign sel_eop_s   = in_endofpacket[grant_idx_s];

    // Ready is one-hot on the granted port; forced low while reset is held
    always_comb begin
        in_ready_s = {NUM_INPUTS{1'b0}};
        for (int i = 0; i < NUM_INPUTS; i++) begin
            in_ready_s[i] = reset_n && grant_valid_s && slot_free_s &&
                            (grant_idx_s == IDX_W'(i));
        end
    end

    // Lock/unlock on packet boundaries; SOP is deliberately ignored
    always_comb begin
        state_d      = state_q;
        lock_idx_d   = lock_idx_q;
        last_grant_d = last_grant_q;
        if (accept_s && (state_q == ST_IDLE)) begin
            last_grant_d = grant_idx_s;
            if (!sel_eop_s) begin
                state_d    = ST_LOCKED;
                lock_idx_d = grant_idx_s;
            end else begin
                state_d    = ST_IDLE;
            end
        end else if (accept_s && sel_eop_s) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // Single output register stage: load on accept, empty on drain, else hold
    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        if (accept_s) begin
            out_valid_d   = 1'b1;
            out_data_d    = sel_data_s;
            out_channel_d = CHANNEL_W'(grant_idx_s);
            out_sop_d     = sel_sop_s;
            out_eop_d     = sel_eop_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            lock_idx_q    <= {IDX_W{1'b0}};
            last_grant_q  <= LAST_RST;
            out_valid_q   <= 1'b0;
            out_data_q    <= {DATA_W{1'b0}};
            out_channel_q <= {CHANNEL_W{1'b0}};
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            lock_idx_q    <= lock_idx_d;
            last_grant_q  <= last_grant_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
        end
    end

    assign in_ready          = in_ready_s;
    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_channel       = out_channel_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;

endmodule
